dragon_hit_detector: RTL and testbench
======================================

DRAGON_HIT_DETECTOR -- requirements
Module: dragon_hit_detector

Interface
REQ-001 SHALL have parameter FLASH_FRAMES, default 8, frames hitFlash stays high after a reported hit (legal 1..63).
REQ-002 SHALL have parameter COOLDOWN_FRAMES, default 16, frames after flash during which hits are ignored (legal 0..63).
REQ-003 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-004 SHALL have port resetN  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port startOfFrame  input  1  one-cycle pulse marking frame start.
REQ-006 SHALL have port pause  input  1  game paused; freezes detection and frame counting.
REQ-007 SHALL have port dragonDR  input  1  dragon bitmap drawing request at current pixel.
REQ-008 SHALL have port shotDR  input  3  per-shot drawing request at current pixel, bit i = shot i.
REQ-009 SHALL have port shotDragonCollision  output  3  registered one-cycle hit pulse, bit i = shot i hit dragon.
REQ-010 SHALL have port hitFlash  output  1  high while in FLASH state.
REQ-011 SHALL have port dragonHitCount  output  8  number of reported hit pulses, saturating.

Function
REQ-012 SHALL detect overlap for shot i in a cycle when dragonDR=1 and shotDR[i]=1.
REQ-013 SHALL keep a 3-bit per-frame reported mask; overlap of shot i is reportable only if mask[i]=0.
REQ-014 SHALL, in state ARMED with pause=0, drive shotDragonCollision[i]=1 in the cycle after a reportable overlap, exactly one cycle, and set mask[i].
REQ-015 SHALL report several shots overlapping in the same cycle in one pulse with multiple bits set.
REQ-016 SHALL clear mask on startOfFrame; an overlap in the startOfFrame cycle is evaluated against the cleared mask (belongs to the new frame).
REQ-017 SHALL implement states ARMED, FLASH, COOLDOWN; ARMED->FLASH in the cycle a pulse is issued.
REQ-018 SHALL, in FLASH, count startOfFrame pulses (pause=0); after FLASH_FRAMES of them go to COOLDOWN, or ARMED if COOLDOWN_FRAMES=0.
REQ-019 SHALL, in COOLDOWN, count startOfFrame pulses (pause=0); after COOLDOWN_FRAMES of them go to ARMED.
REQ-020 SHALL report no overlaps in FLASH or COOLDOWN; shotDragonCollision=0 there, mask not updated.
REQ-021 SHALL ignore startOfFrame for frame counting while pause=1 and report no overlaps while pause=1; state held.
REQ-022 SHALL drive hitFlash=1 exactly while state=FLASH, registered.
REQ-023 SHALL increment dragonHitCount by 1 per pulse cycle regardless of bits set, saturating at 255.
REQ-024 SHALL use a 6-bit frame counter, cleared on every state entry.

Reset
REQ-025 SHALL, on resetN=0, asynchronously force state=ARMED, mask=0, frame counter=0, shotDragonCollision=0, hitFlash=0, dragonHitCount=0.
REQ-026 SHALL abort any FLASH/COOLDOWN in progress on reset mid-operation; first overlap after release is reportable.

Configuration
REQ-027 SHALL, with macro DRAGON_HIT_COUNT_EN defined, implement dragonHitCount per REQ-023.
REQ-028 SHALL, without DRAGON_HIT_COUNT_EN, tie dragonHitCount to 0 and omit the counter; all other behaviour unchanged.

Verification
REQ-029 SHALL test: ARMED, dragonDR=1, shotDR=3'b010 for 5 consecutive cycles -> shotDragonCollision=3'b010 for exactly 1 cycle, one cycle after first overlap; hitFlash=1 next cycle; count=1.
REQ-030 SHALL test: shotDR=3'b101 with dragonDR=1 in one cycle -> single pulse 3'b101, count increments by 1.
REQ-031 SHALL test: after hit, 8 startOfFrame pulses -> hitFlash falls; overlaps during next 16 frames -> no pulse; overlap after 24th frame -> pulse.
REQ-032 SHALL test: pause=1 during FLASH across 5 startOfFrame pulses -> hitFlash stays 1, flash ends 8 unpaused frames after hit.
REQ-033 SHALL test: 300 hits (FLASH_FRAMES=1, COOLDOWN_FRAMES=0) with DRAGON_HIT_COUNT_EN -> count=255; without macro -> count=0.
REQ-034 SHALL test: resetN pulsed low mid-FLASH -> hitFlash=0, count=0 immediately; overlap after release -> pulse.

Source files
------------

// File: rtl/dragon_hit_detector.sv
// rtl/dragon_hit_detector.sv - shot/dragon overlap detector with flash and cooldown windows
// Optional hit counter enabled by defining DRAGON_HIT_COUNT_EN.
`timescale 1ns/1ps
module dragon_hit_detector #(
    parameter int FLASH_FRAMES    = 8,
    parameter int COOLDOWN_FRAMES = 16
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       pause,
    input  logic       dragonDR,
    input  logic [2:0] shotDR,
    output logic [2:0] shotDragonCollision,
    output logic       hitFlash,
    output logic [7:0] dragonHitCount
);
    typedef enum logic [1:0] {ARMED, FLASH, COOLDOWN} state_t;

    localparam logic [5:0] FLASH_LAST = 6'(FLASH_FRAMES - 1);
    localparam logic [5:0] COOL_LAST  = 6'(COOLDOWN_FRAMES - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_mask;
    logic [2:0] r_coll;
    logic       r_hit_flash;
    logic [5:0] r_frame_cnt;
    logic [2:0] w_mask_eff;
    logic [2:0] w_report;
    logic [2:0] w_mask_nxt;
    logic [2:0] w_coll_nxt;
    logic [5:0] w_frame_cnt_nxt;
    logic       w_frame_tick;

    always_comb begin
        // An overlap coinciding with startOfFrame belongs to the new frame.
        w_mask_eff      = startOfFrame ? 3'b000 : r_mask;
        w_report        = {3{dragonDR}} & shotDR & ~w_mask_eff;
        w_frame_tick    = startOfFrame & ~pause;
        w_state_nxt     = r_state;
        w_frame_cnt_nxt = r_frame_cnt;
        w_mask_nxt      = w_mask_eff;
        w_coll_nxt      = 3'b000;
        case (r_state)
            ARMED: begin
                if (!pause && (w_report != 3'b000)) begin
                    w_coll_nxt      = w_report;
                    w_mask_nxt      = w_mask_eff | w_report;
                    w_state_nxt     = FLASH;
                    w_frame_cnt_nxt = 6'd0;
                end
            end
            FLASH: begin
                if (w_frame_tick) begin
                    if (r_frame_cnt == FLASH_LAST) begin
                        w_state_nxt     = (COOLDOWN_FRAMES == 0) ? ARMED : COOLDOWN;
                        w_frame_cnt_nxt = 6'd0;
                    end else begin
                        w_frame_cnt_nxt = r_frame_cnt + 6'd1;
                    end
                end
            end
            COOLDOWN: begin
                if (w_frame_tick) begin
                    if (r_frame_cnt == COOL_LAST) begin
                        w_state_nxt     = ARMED;
                        w_frame_cnt_nxt = 6'd0;
                    end else begin
                        w_frame_cnt_nxt = r_frame_cnt + 6'd1;
                    end
                end
            end
            default: begin
                w_state_nxt     = ARMED;
                w_frame_cnt_nxt = 6'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state     <= ARMED;
            r_mask      <= 3'b000;
            r_coll      <= 3'b000;
            r_hit_flash <= 1'b0;
            r_frame_cnt <= 6'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_mask      <= w_mask_nxt;
            r_coll      <= w_coll_nxt;
            r_hit_flash <= (w_state_nxt == FLASH);
            r_frame_cnt <= w_frame_cnt_nxt;
        end
    end

    assign shotDragonCollision = r_coll;
    assign hitFlash            = r_hit_flash;

`ifdef DRAGON_HIT_COUNT_EN
    logic [7:0] r_hit_count;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_hit_count <= 8'd0;
        end else if ((w_coll_nxt != 3'b000) && (r_hit_count != 8'hFF)) begin
            r_hit_count <= r_hit_count + 8'd1;
        end
    end

    assign dragonHitCount = r_hit_count;
`else
    assign dragonHitCount = 8'd0;
`endif

endmodule

// File: tb/tb_dragon_hit_detector.sv
// tb/tb_dragon_hit_detector.sv - directed table and sequence checks for dragon_hit_detector
`timescale 1ns/1ps
module tb_dragon_hit_detector;
`ifdef DRAGON_HIT_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       resetN2 = 1'b0;
    logic       sof = 1'b0;
    logic       pause = 1'b0;
    logic       dr = 1'b0;
    logic [2:0] shot = 3'b000;
    logic [2:0] coll, coll2;
    logic       flash, flash2;
    logic [7:0] cnt, cnt2;

    int n_cmp = 0;
    int n_fail = 0;

    typedef struct {
        logic       sof;
        logic       pause;
        logic       dr;
        logic [2:0] shot;
        logic [2:0] exp_coll;
        logic       chk_flash;
        logic       exp_flash;
        int         exp_hits;
    } vec_t;

    vec_t tbl[6];

    always #5 clk = ~clk;

    dragon_hit_detector dut (
        .clk(clk), .resetN(resetN), .startOfFrame(sof), .pause(pause),
        .dragonDR(dr), .shotDR(shot), .shotDragonCollision(coll),
        .hitFlash(flash), .dragonHitCount(cnt)
    );

    dragon_hit_detector #(.FLASH_FRAMES(1), .COOLDOWN_FRAMES(0)) dut2 (
        .clk(clk), .resetN(resetN2), .startOfFrame(sof), .pause(pause),
        .dragonDR(dr), .shotDR(shot), .shotDragonCollision(coll2),
        .hitFlash(flash2), .dragonHitCount(cnt2)
    );

    function automatic int ec(input int n);
        if (!CNT_EN) return 0;
        return (n > 255) ? 255 : n;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic s, input logic p, input logic d, input logic [2:0] sh);
        @(negedge clk);
        sof = s; pause = p; dr = d; shot = sh;
        @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            step(1'b1, 1'b0, 1'b0, 3'b000);
            chk($sformatf("%s sof%0d coll", tag, k), int'(coll), 0);
            step(1'b0, 1'b0, 1'b1, 3'b111);
            chk($sformatf("%s ov%0d coll", tag, k), int'(coll), 0);
        end
    endtask

    initial begin
        int pulses;
        // 5 cycles of overlap on shot 1, then idle
        tbl[0] = '{1'b0, 1'b0, 1'b1, 3'b010, 3'b010, 1'b0, 1'b0, 1};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 3'b010, 3'b000, 1'b1, 1'b1, 1};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 3'b010, 3'b000, 1'b1, 1'b1, 1};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 3'b010, 3'b000, 1'b1, 1'b1, 1};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 3'b010, 3'b000, 1'b1, 1'b1, 1};
        tbl[5] = '{1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b1, 1'b1, 1};

        repeat (2) @(posedge clk);
        #1;
        chk("reset coll", int'(coll), 0);
        chk("reset flash", int'(flash), 0);
        chk("reset cnt", int'(cnt), 0);
        @(negedge clk);
        resetN = 1'b1;

        for (int i = 0; i < 6; i++) begin
            step(tbl[i].sof, tbl[i].pause, tbl[i].dr, tbl[i].shot);
            chk($sformatf("tbl%0d coll", i), int'(coll), int'(tbl[i].exp_coll));
            if (tbl[i].chk_flash) chk($sformatf("tbl%0d flash", i), int'(flash), int'(tbl[i].exp_flash));
            chk($sformatf("tbl%0d cnt", i), int'(cnt), ec(tbl[i].exp_hits));
        end

        // Flash lasts 8 frames, then 16 cooldown frames ignore overlaps
        frames(7, "flash");
        chk("flash after 7", int'(flash), 1);
        step(1'b1, 1'b0, 1'b0, 3'b000);
        chk("flash after 8", int'(flash), 0);
        step(1'b0, 1'b0, 1'b1, 3'b111);
        chk("cool ov coll", int'(coll), 0);
        frames(15, "cool");
        chk("cool flash", int'(flash), 0);
        step(1'b1, 1'b0, 1'b0, 3'b000);
        step(1'b0, 1'b0, 1'b1, 3'b101);
        chk("multi coll", int'(coll), 5);
        chk("multi cnt", int'(cnt), ec(2));
        step(1'b0, 1'b0, 1'b0, 3'b000);
        chk("multi coll off", int'(coll), 0);
        chk("multi flash", int'(flash), 1);

        // Paused frames do not advance the flash window
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b1, 1'b1, 3'b111);
            chk($sformatf("pause%0d flash", k), int'(flash), 1);
        end
        for (int k = 0; k < 7; k++) step(1'b1, 1'b0, 1'b0, 3'b000);
        chk("unpaused 7 flash", int'(flash), 1);
        step(1'b1, 1'b0, 1'b0, 3'b000);
        chk("unpaused 8 flash", int'(flash), 0);
        for (int k = 0; k < 16; k++) step(1'b1, 1'b0, 1'b0, 3'b000);
        step(1'b0, 1'b1, 1'b1, 3'b111);
        chk("paused armed coll", int'(coll), 0);
        chk("paused armed flash", int'(flash), 0);
        step(1'b0, 1'b0, 1'b1, 3'b001);
        chk("armed again coll", int'(coll), 1);
        chk("armed again cnt", int'(cnt), ec(3));

        // Asynchronous reset in the middle of FLASH
        step(1'b1, 1'b0, 1'b0, 3'b000);
        step(1'b1, 1'b0, 1'b0, 3'b000);
        chk("pre-reset flash", int'(flash), 1);
        #2;
        resetN = 1'b0;
        #1;
        chk("async rst flash", int'(flash), 0);
        chk("async rst cnt", int'(cnt), 0);
        @(negedge clk);
        resetN = 1'b1;
        step(1'b0, 1'b0, 1'b1, 3'b100);
        chk("post-rst coll", int'(coll), 4);
        chk("post-rst cnt", int'(cnt), ec(1));
        step(1'b0, 1'b0, 1'b0, 3'b000);
        chk("post-rst flash", int'(flash), 1);

        // Counter saturation with a one-frame flash and no cooldown
        @(negedge clk);
        resetN2 = 1'b0;
        @(negedge clk);
        resetN2 = 1'b1;
        pulses = 0;
        for (int k = 0; k < 300; k++) begin
            step(1'b0, 1'b0, 1'b1, 3'b010);
            if (coll2 == 3'b010) pulses++;
            step(1'b1, 1'b0, 1'b0, 3'b000);
        end
        chk("sat pulses", pulses, 300);
        chk("sat cnt", int'(cnt2), ec(300));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
